// File: rtl/vga_pkg.sv
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared VGA timing constants and coordinate type, reused by the
//            timing generator and by downstream renderers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;

    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Free-running VGA raster counters with blanking, frame pulse and
//            sync outputs lagged one clock to match a registered RGB stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    output logic [COORD_W-1:0] DrawX,
    output logic [COORD_W-1:0] DrawY,
    output logic               blank,
    output logic               hs,
    output logic               vs,
    output logic               vblank,
    output logic               frame_start,
    output logic [7:0]         frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST       = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST       = coord_t'(V_TOTAL - 1);
    localparam coord_t H_ACT        = coord_t'(H_VISIBLE);
    localparam coord_t V_ACT        = coord_t'(V_VISIBLE);
    localparam coord_t H_SYNC_FIRST = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t H_SYNC_LAST  = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam coord_t V_SYNC_FIRST = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t V_SYNC_LAST  = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic   x_wrap;
    logic   y_wrap;
    logic   frame_wrap;
    coord_t next_x;
    coord_t next_y;

    always_comb begin
        x_wrap     = (DrawX == H_LAST);
        y_wrap     = (DrawY == V_LAST);
        frame_wrap = x_wrap && y_wrap;
        next_x     = x_wrap ? '0 : DrawX + coord_t'(1);
        next_y     = DrawY;
        if (x_wrap) begin
            next_y = y_wrap ? '0 : DrawY + coord_t'(1);
        end
    end

    // Flags are computed from next-state coordinates so they land on the same
    // edge as the position they describe; syncs use the current position and
    // therefore trail DrawX/DrawY by one clock.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX       <= '0;
            DrawY       <= '0;
            blank       <= 1'b0;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 8'd0;
            hs          <= 1'b1;
            vs          <= 1'b1;
        end else begin
            DrawX       <= next_x;
            DrawY       <= next_y;
            blank       <= (next_x < H_ACT) && (next_y < V_ACT);
            vblank      <= (next_y >= V_ACT);
            frame_start <= frame_wrap;
            if (frame_wrap) begin
                frame_count <= frame_count + 8'd1;
            end
            hs          <= ~in_range(DrawX, H_SYNC_FIRST, H_SYNC_LAST);
            vs          <= ~in_range(DrawY, V_SYNC_FIRST, V_SYNC_LAST);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Self-checking bench for vga_timing_gen using a reduced raster.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

    // Reduced raster so hundreds of frames fit in a short run
    localparam int HV = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VV = 6;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;

    localparam logic [32:0] RESET_VEC = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};

    logic       vga_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       vblank;
    logic       frame_start;
    logic [7:0] frame_count;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen #(
        .H_VISIBLE (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_VISIBLE (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .hs          (hs),
        .vs          (vs),
        .vblank      (vblank),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [32:0] sb_q[$];

    int mx, my, px, py, mfc;
    int hs_low, vs_low, fs_cnt;
    logic       prev_vs;
    logic [7:0] prev_fc;
    logic [9:0] prev_x, prev_y;
    logic       wrap_seen;

    function automatic logic [32:0] observed();
        return {DrawX, DrawY, blank, hs, vs, vblank, frame_start, frame_count};
    endfunction

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; px = 0; py = 0; mfc = 0;
        prev_vs = 1'b1; prev_fc = 8'd0; prev_x = 10'd0; prev_y = 10'd0;
    endtask

    // Spec-level model: position advances, flags describe the new position,
    // syncs describe the position held during the previous cycle.
    task automatic model_step(output logic [32:0] e);
        logic fs;
        px = mx;
        py = my;
        if (mx == HT - 1) begin
            mx = 0;
            my = (my == VT - 1) ? 0 : my + 1;
        end else begin
            mx = mx + 1;
        end
        fs = (mx == 0) && (my == 0);
        if (fs) mfc = (mfc + 1) % 256;
        e = {10'(mx), 10'(my),
             (mx < HV) && (my < VV),
             !((px >= HV + HF) && (px <= HV + HF + HS - 1)),
             !((py >= VV + VF) && (py <= VV + VF + VS - 1)),
             (my >= VV),
             fs,
             8'(mfc)};
    endtask

    task automatic cycle();
        logic [32:0] e;
        model_step(e);
        sb_q.push_back(e);
        @(posedge vga_clk);
        #1;
        check("cycle", observed(), sb_q.pop_front());
        if (!hs) hs_low++;
        if (!vs) vs_low++;
        if (frame_start) fs_cnt++;
        if (prev_vs && !vs)
            check("vs_start_pos", {13'd0, prev_x, prev_y}, {13'd0, 10'd0, 10'(VV + VF)});
        if (prev_fc == 8'd255 && frame_count == 8'd0) begin
            wrap_seen = 1'b1;
            check("fc_wrap_frame_start", {32'd0, frame_start}, 33'd1);
        end
        prev_vs = vs;
        prev_fc = frame_count;
        prev_x  = DrawX;
        prev_y  = DrawY;
    endtask

    initial begin
        logic found;
        hs_low = 0; vs_low = 0; fs_cnt = 0; wrap_seen = 1'b0;
        model_reset();

        // Held in reset across clock edges
        repeat (3) @(posedge vga_clk);
        #1;
        check("reset_state", observed(), RESET_VEC);

        @(negedge vga_clk);
        reset_n = 1'b1;
        cycle();
        check("first_edge", {22'd0, DrawX, blank}, {22'd0, 10'd1, 1'b1});

        // Rest of the short first frame plus 256 full frames, ending at (0,0)
        repeat (257 * FRAME - 1) cycle();
        check("fs_pulses", 33'(fs_cnt), 33'd257);
        check("hs_low_clocks", 33'(hs_low), 33'(257 * VT * HS));
        check("vs_low_clocks", 33'(vs_low), 33'(257 * VS * HT));
        check("fc_wrap_seen", {32'd0, wrap_seen}, 33'd1);
        check("end_position", observed(),
              {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1});

        // Mid-frame asynchronous reset
        found = 1'b0;
        for (int i = 0; i < FRAME && !found; i++) begin
            cycle();
            if (DrawX == 10'd5 && DrawY == 10'd3) found = 1'b1;
        end
        check("reach_mid_frame", {32'd0, found}, 33'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset", observed(), RESET_VEC);
        sb_q.delete();
        @(posedge vga_clk);
        #1;
        check("reset_hold", observed(), RESET_VEC);

        @(negedge vga_clk);
        reset_n = 1'b1;
        model_reset();
        cycle();
        check("x_after_release", {23'd0, DrawX}, 33'd1);
        repeat (2 * HT) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in clocks.
REQ-004 Parameter H_BP, default 48, horizontal back porch in clocks.
REQ-005 Parameter V_VISIBLE, default 480, active lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 Parameter V_BP, default 33, vertical back porch in lines.
REQ-009 vga_clk  input  1  pixel clock; the only clock; all state changes on its rising edge.
REQ-010 reset_n  input  1  asynchronous, active-low reset.
REQ-011 DrawX  output  10  current pixel column; registered.
REQ-012 DrawY  output  10  current pixel line; registered.
REQ-013 blank  output  1  display-active flag; 1 means DrawX/DrawY lie in the visible area (renderers drive colour only when high).
REQ-014 hs  output  1  horizontal sync, active-low, delayed to match renderer latency.
REQ-015 vs  output  1  vertical sync, active-low, delayed to match renderer latency.
REQ-016 vblank  output  1  high while DrawY >= V_VISIBLE.
REQ-017 frame_start  output  1  one-cycle pulse when the counters wrap to (0,0).
REQ-018 frame_count  output  8  frames completed since reset, for sprite animation.

Function
REQ-019 Horizontal counter DrawX: +1 per clock, 0..H_TOTAL-1, where H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (default 800); wraps to 0.
REQ-020 Vertical counter DrawY: +1 on the clock where DrawX wraps, 0..V_TOTAL-1, where V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (default 525); wraps to 0 on the same clock when both wrap.
REQ-021 blank, vblank and frame_start: registered from next-state counter values, so they change on the same edge as DrawX/DrawY they describe.
REQ-022 blank = 1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
REQ-023 Raw hsync is low iff DrawX is in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1]; default range 656..751.
REQ-024 Raw vsync is low iff DrawY is in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1]; default range 490..491.
REQ-025 hs/vs equal raw hsync/vsync delayed by exactly one vga_clk, aligning them with the downstream renderer's one-cycle registered RGB.
REQ-026 frame_start = 1 for exactly the one cycle in which (DrawX,DrawY) = (0,0) after a wrap; it is not asserted for the reset state.
REQ-027 frame_count increments modulo 256 on the same edge that frame_start rises (255 -> 0).
REQ-028 Counter arithmetic is 10-bit unsigned; parameters are required to keep H_TOTAL and V_TOTAL <= 1024.
REQ-029 No input besides clock and reset; the block free-runs continuously.

Reset
REQ-030 While reset_n = 0, all outputs are held regardless of clock: DrawX = 0, DrawY = 0, blank = 0, vblank = 0, frame_start = 0, frame_count = 0, hs = 1, vs = 1.
REQ-031 First rising edge after reset_n deasserts: DrawX = 1, DrawY = 0, blank = 1; the first frame is one pixel short and not flagged by frame_start.
REQ-032 Reset asserted mid-frame returns all state to REQ-030 values immediately (asynchronously).

Structure
REQ-033 Timing defaults, H_TOTAL/V_TOTAL and the coordinate width (10) are defined as constants in shared package vga_pkg, reused by renderers.
REQ-034 Single module; no sub-module (the two counters are too small to justify one).

Verification
REQ-035 Reset, then run 800 clocks -> DrawX sequence 1..799,0 and DrawY steps 0 -> 1 on the wrap edge.
REQ-036 Line 0: blank high for DrawX 0..639, low for 640..799; hs low exactly when the previous cycle's DrawX was 656..751 (96 clocks, one-cycle lag).
REQ-037 Run one full frame (420000 clocks) -> vs low for 1600 clocks, starting one clock after DrawY becomes 490; vblank high for DrawY 480..524.
REQ-038 At DrawX = 799, DrawY = 524 -> next edge gives (0,0), frame_start = 1 for one cycle, frame_count 0 -> 1.
REQ-039 Force 256 frames -> frame_count wraps 255 -> 0 while frame_start still pulses.
REQ-040 Assert reset_n low at DrawX = 300, DrawY = 200, between clock edges -> all outputs take REQ-030 values before the next edge; after release, DrawX = 1.
